// File: rtl/srl16_fifo_ctrl.sv
// srl16_fifo_ctrl: a 16-deep FIFO built on shift-register LUTs.
// All bit slices shift together on a push. The read address follows the
// occupancy count, so M_DATA always shows the oldest entry.
// Status outputs come only from the registered occupancy count.

// Behavioural stand-in for one SRL16E: a 16-bit shift register with a
// clock enable and an addressable tap.
module srl16_fifo_ctrl_srl16e (
  input  logic       CLK,
  input  logic       CE,
  input  logic [3:0] A,
  input  logic       D,
  output logic       Q
);
  logic [15:0] r_sr;

  // Shift the new bit in at tap 0 on every enabled edge; the contents are never reset.
  always_ff @(posedge CLK) begin
    if (CE) r_sr <= {r_sr[14:0], D};
  end

  assign Q = r_sr[A];
endmodule

// State table (decoded from the occupancy count cnt)
//   state      | meaning
//   ST_EMPTY   | cnt = 0, nothing to read, writes accepted
//   ST_PARTIAL | cnt = 1..15, reads and writes both possible
//   ST_FULL    | cnt = 16, writes refused
module srl16_fifo_ctrl #(
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [WIDTH-1:0] S_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [WIDTH-1:0] M_DATA,
  output logic [4:0]       LEVEL,
  output logic             ALMOST_FULL,
  output logic             ALMOST_EMPTY
);
  localparam logic [4:0] AF_THR = 5'(AF_LEVEL);
  localparam logic [4:0] AE_THR = 5'(AE_LEVEL);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  logic [4:0] r_cnt;
  logic [4:0] w_cnt_nxt;
  state_t     w_state;
  logic       w_push;
  logic       w_pop;
  logic [3:0] w_addr;

  // Hold the occupancy count. Reset wins over every other input.
  always_ff @(posedge CLK) begin
    if (RST) r_cnt <= 5'd0;
    else     r_cnt <= w_cnt_nxt;
  end

  // Decode the state from the count, then form the handshakes, the next count and the read address.
  always_comb begin
    w_state   = ST_PARTIAL;
    w_cnt_nxt = r_cnt;
    w_addr    = 4'd0;
    if (r_cnt == 5'd0)       w_state = ST_EMPTY;
    else if (r_cnt == 5'd16) w_state = ST_FULL;

    S_READY = (w_state != ST_FULL);
    M_VALID = (w_state != ST_EMPTY);
    w_push  = S_VALID & S_READY;
    w_pop   = M_VALID & M_READY;

    if (FLUSH)                w_cnt_nxt = 5'd0;
    else if (w_push & ~w_pop) w_cnt_nxt = r_cnt + 5'd1;
    else if (w_pop & ~w_push) w_cnt_nxt = r_cnt - 5'd1;

    // The oldest entry sits at tap cnt-1. On a push together with a pop, the
    // shift moves the next-oldest entry into that same tap.
    if (r_cnt != 5'd0) w_addr = 4'(r_cnt - 5'd1);
  end

  // One shift register per data bit. All bits share the push enable and the read address.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    srl16_fifo_ctrl_srl16e u_srl (
      .CLK (CLK),
      .CE  (w_push),
      .A   (w_addr),
      .D   (S_DATA[i]),
      .Q   (M_DATA[i])
    );
  end

  assign LEVEL        = r_cnt;
  assign ALMOST_FULL  = (r_cnt >= AF_THR);
  assign ALMOST_EMPTY = (r_cnt <= AE_THR);
endmodule

// File: doc/srl16_fifo_ctrl.md
SRL16_FIFO_CTRL -- requirements
Module: srl16_fifo_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 8, data width in bits; one SRL16E per bit.
- AF_LEVEL, 14, ALMOST_FULL threshold (1..16).
- AE_LEVEL, 2, ALMOST_EMPTY threshold (0..15).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK, in, 1, single clock, rising edge.
- RST, in, 1, synchronous reset, active-high.
- FLUSH, in, 1, synchronous occupancy clear.
- S_VALID, in, 1, write request.
- S_READY, out, 1, write accept.
- S_DATA, in, WIDTH, write data.
- M_VALID, out, 1, read data valid.
- M_READY, in, 1, read accept.
- M_DATA, out, WIDTH, read data.
- LEVEL, out, 5, occupancy 0..16.
- ALMOST_FULL, out, 1, occupancy flag.
- ALMOST_EMPTY, out, 1, occupancy flag.

REQ-003 The single clock is CLK; reset is RST, synchronous and active-high; no other clock or reset SHALL exist.

Function
REQ-004 Storage SHALL be WIDTH SRL16E instances sharing one CE and one 4-bit address, with D = S_DATA[i] and Q = M_DATA[i].
REQ-005 push = S_VALID & S_READY; pop = M_VALID & M_READY; shared SRL CE SHALL equal push (not gated by pop).
REQ-006 A 5-bit register cnt SHALL hold occupancy: push only -> cnt+1; pop only -> cnt-1; both or neither -> unchanged.
REQ-007 Decoded state SHALL be EMPTY (cnt=0), PARTIAL (1..15), FULL (cnt=16); no other encoding is permitted.
REQ-008 S_READY SHALL be 1 iff state != FULL; a push while FULL is not accepted even if pop is asserted in the same cycle.
REQ-009 M_VALID SHALL be 1 iff state != EMPTY; a pop while EMPTY is impossible, and a push into EMPTY is not visible on M_VALID until the next cycle (latency 1).
REQ-010 The SRL address SHALL be cnt-1 (4 bits) when cnt>0, and 0 when cnt=0; M_DATA SHALL therefore show the oldest entry combinationally.
REQ-011 On simultaneous push and pop, the address SHALL stay cnt-1: the shift moves the next-oldest entry into that position, so order is preserved.
REQ-012 S_READY, M_VALID, LEVEL, ALMOST_FULL and ALMOST_EMPTY SHALL derive only from registered state (no combinational path from S_VALID or M_READY).
REQ-013 LEVEL SHALL equal cnt.
REQ-014 ALMOST_FULL SHALL be (cnt >= AF_LEVEL); ALMOST_EMPTY SHALL be (cnt <= AE_LEVEL).
REQ-015 FLUSH SHALL set cnt to 0 at the next edge, overriding push and pop in that cycle; SRL CE is still driven by push, so data shifts in but is discarded.
REQ-016 FIFO order SHALL be strict: data is read in write order, with no loss or duplication.

Reset
REQ-017 RST SHALL set cnt to 0, giving S_READY=1, M_VALID=0, LEVEL=0, ALMOST_FULL=0 and ALMOST_EMPTY=1 after the edge.
REQ-018 RST SHALL take priority over FLUSH, push and pop; SRL contents are not cleared, and stale contents are never presented as valid.
REQ-019 RST asserted mid-operation (any cnt) SHALL return the block to EMPTY in one cycle; M_DATA is don't-care while M_VALID=0.

Verification
REQ-020 The bench SHALL cover:
- Write 0x11..0x20 (16 words) with M_READY=0 -> LEVEL=16, S_READY=0, ALMOST_FULL asserted when LEVEL reaches 14; then read all -> 0x11..0x20 in order, M_VALID=0 at LEVEL=0.
- From LEVEL=5, push and pop every cycle for 20 cycles -> LEVEL stays 5 and output order matches input order.
- At FULL, S_VALID=1 and M_READY=1 together -> pop only, LEVEL becomes 15, the pushed word is not accepted, S_READY=1 on the next cycle.
- Push 0xA5 into EMPTY -> M_VALID=0 in the same cycle, then M_VALID=1 and M_DATA=0xA5 the next cycle.
- At LEVEL=9, FLUSH=1 with S_VALID=1 -> LEVEL=0, M_VALID=0, ALMOST_EMPTY=1; a subsequent push of 0x3C reads back 0x3C.
- At LEVEL=7, RST=1 together with FLUSH and push -> all outputs at reset values; the next read returns only data written after reset.
